// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
package fetch_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned PC_STEP_DEF    = 4;
   localparam int unsigned COUNT_WIDTH    = 32;
   // Low PC bits that must be zero for a legal redirect target
   localparam int unsigned ALIGN_MASK     = 3;

   typedef enum logic {
      ST_ISSUE = 1'b0,
      ST_ACKED = 1'b1
   } state_e;

endpackage

// File: rtl/fetch_pc_sequencer_if.sv
// DIR/ack handshake between the fetch PC sequencer and the pipeline input.
interface fetch_pc_sequencer_if #(
   parameter int unsigned ADDR_WIDTH = 32
);

   logic                  pipeline_DIR;
   logic [ADDR_WIDTH-1:0] pc_out;
   logic                  ack_from_pipeline;

   modport master (
      output pipeline_DIR,
      output pc_out,
      input  ack_from_pipeline
   );

   modport slave (
      input  pipeline_DIR,
      input  pc_out,
      output ack_from_pipeline
   );

endinterface

// File: rtl/fetch_pc_sequencer_pc_redirect_latch.sv
// Holds a redirect target that arrived while a PC was being presented.
module pc_redirect_latch #(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  capture,
   input  logic                  clear,
   input  logic [ADDR_WIDTH-1:0] target_in,
   output logic                  pending,
   output logic [ADDR_WIDTH-1:0] target
);

   // Acceptance clears the flag; a later capture overwrites an earlier target
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
         target  <= '0;
      end else if (clear) begin
         pending <= 1'b0;
      end else if (capture) begin
         pending <= 1'b1;
         target  <= target_in;
      end
   end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC sequencer: presents a PC stream over the DIR/ack four-phase handshake.
// Optional FETCH_PC_ALIGN_CHECK_EN: misaligned redirect targets are dropped and
// flagged on misalign_err.
module fetch_pc_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter int unsigned           PC_STEP    = PC_STEP_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   halt,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc,
   fetch_pc_sequencer_if.master   bus,
   output logic                   redirect_pending,
   output logic [COUNT_WIDTH-1:0] issue_count,
   output logic                   misalign_err
);

   state_e                  state_q, state_d;
   logic                    dir_q, dir_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [COUNT_WIDTH-1:0]  count_d;
   logic                    err_d;
   logic                    capture_c, clear_c;
   logic                    misalign_c, redirect_ok_c;
   logic [ADDR_WIDTH-1:0]   pend_target;

   assign bus.pipeline_DIR = dir_q;
   assign bus.pc_out       = pc_q;

   // Classify the incoming redirect as usable or rejected
`ifdef FETCH_PC_ALIGN_CHECK_EN
   assign misalign_c = redirect_valid && ((redirect_pc[1:0] & 2'(ALIGN_MASK)) != 2'b00);
`else
   assign misalign_c = 1'b0;
`endif
   assign redirect_ok_c = redirect_valid && !misalign_c;

   pc_redirect_latch #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_latch (
      .clk       (clk),
      .reset     (reset),
      .capture   (capture_c),
      .clear     (clear_c),
      .target_in (redirect_pc),
      .pending   (redirect_pending),
      .target    (pend_target)
   );

   // Next state, DIR, PC and counter; pc_out never changes while DIR is high
   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      pc_d      = pc_q;
      count_d   = issue_count;
      err_d     = misalign_c;
      capture_c = 1'b0;
      clear_c   = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            if (!dir_q) begin
               if (!halt) dir_d = 1'b1;
               if (redirect_ok_c) pc_d = redirect_pc;
            end else if (bus.ack_from_pipeline) begin
               dir_d   = 1'b0;
               count_d = issue_count + COUNT_WIDTH'(1);
               state_d = ST_ACKED;
               clear_c = 1'b1;
               if (redirect_ok_c)         pc_d = redirect_pc;
               else if (redirect_pending) pc_d = pend_target;
               else                       pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
            end else begin
               capture_c = redirect_ok_c;
            end
         end
         ST_ACKED: begin
            dir_d = 1'b0;
            if (!bus.ack_from_pipeline) state_d = ST_ISSUE;
            if (redirect_ok_c) pc_d = redirect_pc;
         end
         default: state_d = ST_ISSUE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ISSUE;
         dir_q        <= 1'b0;
         pc_q         <= RESET_PC;
         issue_count  <= '0;
         misalign_err <= 1'b0;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         pc_q         <= pc_d;
         issue_count  <= count_d;
         misalign_err <= err_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: default-reset and wrap-reset instances.
module tb_fetch_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, halt, rv;
   logic [31:0] rpc;
   logic        pend, err;
   logic [31:0] cnt;

   logic        reset_b;
   logic        pend_b, err_b;
   logic [31:0] cnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_pc_sequencer_if #(.ADDR_WIDTH(32)) bus_a ();
   fetch_pc_sequencer_if #(.ADDR_WIDTH(32)) bus_b ();

   fetch_pc_sequencer #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'd0),
      .PC_STEP    (4)
   ) dut_a (
      .clk              (clk),
      .reset            (reset),
      .halt             (halt),
      .redirect_valid   (rv),
      .redirect_pc      (rpc),
      .bus              (bus_a),
      .redirect_pending (pend),
      .issue_count      (cnt),
      .misalign_err     (err)
   );

   fetch_pc_sequencer #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'hFFFF_FFFC),
      .PC_STEP    (4)
   ) dut_b (
      .clk              (clk),
      .reset            (reset_b),
      .halt             (1'b0),
      .redirect_valid   (1'b0),
      .redirect_pc      (32'd0),
      .bus              (bus_b),
      .redirect_pending (pend_b),
      .issue_count      (cnt_b),
      .misalign_err     (err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full handshake on instance A with a single-cycle ack response
   task automatic hs(input logic [31:0] exp_pc, input logic [31:0] exp_next,
                     input logic [31:0] exp_cnt);
      check("hs_dir_high", 32'(bus_a.pipeline_DIR), 32'd1);
      check("hs_pc", bus_a.pc_out, exp_pc);
      bus_a.ack_from_pipeline = 1'b1;
      step();
      check("hs_dir_drop", 32'(bus_a.pipeline_DIR), 32'd0);
      check("hs_count", cnt, exp_cnt);
      bus_a.ack_from_pipeline = 1'b0;
      step();
      check("hs_dir_low1", 32'(bus_a.pipeline_DIR), 32'd0);
      step();
      check("hs_dir_rise", 32'(bus_a.pipeline_DIR), 32'd1);
      check("hs_next_pc", bus_a.pc_out, exp_next);
   endtask

   initial begin
      reset = 1'b1; halt = 1'b0; rv = 1'b0; rpc = 32'd0;
      bus_a.ack_from_pipeline = 1'b0;
      reset_b = 1'b1;
      bus_b.ack_from_pipeline = 1'b0;
      repeat (2) step();

      // Reset state
      check("rst_dir", 32'(bus_a.pipeline_DIR), 32'd0);
      check("rst_pc", bus_a.pc_out, 32'd0);
      check("rst_pend", 32'(pend), 32'd0);
      check("rst_cnt", cnt, 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Release: DIR one cycle later, then sequential stream
      @(negedge clk) reset = 1'b0;
      step();
      check("first_dir", 32'(bus_a.pipeline_DIR), 32'd1);
      check("first_pc", bus_a.pc_out, 32'd0);
      hs(32'd0,  32'd4,  32'd1);
      hs(32'd4,  32'd8,  32'd2);
      hs(32'd8,  32'd12, 32'd3);
      hs(32'd12, 32'd16, 32'd4);

      // Redirect while DIR high and ack low: held pending, pc_out stable
      rv = 1'b1; rpc = 32'h100;
      step();
      rv = 1'b0;
      check("pend_set", 32'(pend), 32'd1);
      check("pend_dir", 32'(bus_a.pipeline_DIR), 32'd1);
      check("pend_pc_hold", bus_a.pc_out, 32'd16);
      step();
      check("pend_hold2", 32'(pend), 32'd1);
      check("pend_pc_hold2", bus_a.pc_out, 32'd16);
      bus_a.ack_from_pipeline = 1'b1;
      step();
      check("pend_acc_dir", 32'(bus_a.pipeline_DIR), 32'd0);
      check("pend_acc_pc", bus_a.pc_out, 32'h100);
      check("pend_acc_clr", 32'(pend), 32'd0);
      check("pend_acc_cnt", cnt, 32'd5);
      step();
      check("acked_stay", 32'(bus_a.pipeline_DIR), 32'd0);
      bus_a.ack_from_pipeline = 1'b0;
      step();
      check("acked_leave", 32'(bus_a.pipeline_DIR), 32'd0);
      step();
      check("redir_dir", 32'(bus_a.pipeline_DIR), 32'd1);
      check("redir_pc", bus_a.pc_out, 32'h100);
      hs(32'h100, 32'h104, 32'd6);

      // Same-cycle redirect beats the pending target
      rv = 1'b1; rpc = 32'h100;
      step();
      check("sc_pend", 32'(pend), 32'd1);
      rpc = 32'h200;
      bus_a.ack_from_pipeline = 1'b1;
      step();
      rv = 1'b0;
      check("sc_pc", bus_a.pc_out, 32'h200);
      check("sc_clr", 32'(pend), 32'd0);
      check("sc_cnt", cnt, 32'd7);
      bus_a.ack_from_pipeline = 1'b0;
      step();
      step();
      check("sc_dir", 32'(bus_a.pipeline_DIR), 32'd1);
      check("sc_pc2", bus_a.pc_out, 32'h200);

      // Misaligned redirect target
      rv = 1'b1; rpc = 32'h102;
      step();
      rv = 1'b0;
`ifdef FETCH_PC_ALIGN_CHECK_EN
      check("mis_err", 32'(err), 32'd1);
      check("mis_pend", 32'(pend), 32'd0);
      step();
      check("mis_err_clr", 32'(err), 32'd0);
      hs(32'h200, 32'h204, 32'd8);
`else
      check("mis_err", 32'(err), 32'd0);
      check("mis_pend", 32'(pend), 32'd1);
      step();
      check("mis_err_clr", 32'(err), 32'd0);
      hs(32'h200, 32'h102, 32'd8);
`endif

      // Halt held through reset release; ack ignored while DIR low
      reset = 1'b1; halt = 1'b1;
      step();
      check("halt_rst_dir", 32'(bus_a.pipeline_DIR), 32'd0);
      @(negedge clk) reset = 1'b0;
      bus_a.ack_from_pipeline = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("halt_dir_low", 32'(bus_a.pipeline_DIR), 32'd0);
      end
      bus_a.ack_from_pipeline = 1'b0;
      check("halt_cnt", cnt, 32'd0);
      rv = 1'b1; rpc = 32'h40;
      step();
      rv = 1'b0;
      check("halt_redir_pc", bus_a.pc_out, 32'h40);
      check("halt_redir_pend", 32'(pend), 32'd0);
      halt = 1'b0;
      step();
      check("unhalt_dir", 32'(bus_a.pipeline_DIR), 32'd1);
      check("unhalt_pc", bus_a.pc_out, 32'h40);

      // Halt during an in-flight handshake: it still completes
      halt = 1'b1;
      bus_a.ack_from_pipeline = 1'b1;
      step();
      check("hf_dir", 32'(bus_a.pipeline_DIR), 32'd0);
      check("hf_cnt", cnt, 32'd1);
      check("hf_pc", bus_a.pc_out, 32'h44);
      bus_a.ack_from_pipeline = 1'b0;
      repeat (3) step();
      check("hf_held", 32'(bus_a.pipeline_DIR), 32'd0);
      halt = 1'b0;
      step();
      check("hf_rise", 32'(bus_a.pipeline_DIR), 32'd1);
      check("hf_rise_pc", bus_a.pc_out, 32'h44);

      // Asynchronous reset mid-handshake drops DIR and the pending target
      rv = 1'b1; rpc = 32'h300;
      step();
      rv = 1'b0;
      check("ar_pend", 32'(pend), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("ar_dir", 32'(bus_a.pipeline_DIR), 32'd0);
      check("ar_pc", bus_a.pc_out, 32'd0);
      check("ar_pend_clr", 32'(pend), 32'd0);
      check("ar_cnt", cnt, 32'd0);

      // Instance B: PC wraps from all-ones minus 3 to 0
      @(negedge clk) reset_b = 1'b0;
      step();
      check("b_first_dir", 32'(bus_b.pipeline_DIR), 32'd1);
      check("b_first_pc", bus_b.pc_out, 32'hFFFF_FFFC);
      bus_b.ack_from_pipeline = 1'b1;
      step();
      check("b_wrap_pc", bus_b.pc_out, 32'd0);
      check("b_cnt", cnt_b, 32'd1);
      bus_b.ack_from_pipeline = 1'b0;
      step();
      step();
      check("b_dir2", 32'(bus_b.pipeline_DIR), 32'd1);
      check("b_pc2", bus_b.pc_out, 32'd0);
      #2 reset_b = 1'b1;
      #1;
      check("b_ar_dir", 32'(bus_b.pipeline_DIR), 32'd0);
      check("b_ar_pc", bus_b.pc_out, 32'hFFFF_FFFC);
      check("b_ar_cnt", cnt_b, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
